alu_cpu_core: RTL and testbench



---
 rtl/alu_cpu_pkg.sv | 58 +++++
 rtl/alu_cpu_core_if.sv | 39 +++
 rtl/alu_cpu_alu.sv | 79 +++++++
 rtl/alu_cpu_core.sv | 122 ++++++++++++
 tb/tb_alu_cpu_core.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/alu_cpu_pkg.sv
// rtl/alu_cpu_pkg.sv - shared opcodes, state encoding, instruction layout and default ROM
//
// Purpose: common definitions for the ALU CPU core and its ALU.
// Contents:
//   OP_*          opcode values
//   state_t       sequencer states (FETCH, EXEC, HOLD, HALTED)
//   instr_t       24-bit instruction word {opcode, operand A, operand B}
//   rom_image_t   packed ROM image, 256 words of 24 bits, word i at [i*24 +: 24]
//   default_rom() builds the default program image
// Optional feature macro: ALU_CPU_MUL_EN (adds OP_MUL, opcode 0x08).
package alu_cpu_pkg;

  localparam logic [7:0] OP_ADD  = 8'h00;
  localparam logic [7:0] OP_SUB  = 8'h01;
  localparam logic [7:0] OP_AND  = 8'h02;
  localparam logic [7:0] OP_OR   = 8'h03;
  localparam logic [7:0] OP_XOR  = 8'h04;
  localparam logic [7:0] OP_NOT  = 8'h05;
  localparam logic [7:0] OP_SHL  = 8'h06;
  localparam logic [7:0] OP_SHR  = 8'h07;
  localparam logic [7:0] OP_MUL  = 8'h08;
  localparam logic [7:0] OP_INC  = 8'h09;
  localparam logic [7:0] OP_DEC  = 8'h0A;
  localparam logic [7:0] OP_HALT = 8'hFF;

  localparam int ROM_MAX = 256;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_EXEC,
    ST_HOLD,
    ST_HALTED
  } state_t;

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] a;
    logic [7:0] b;
  } instr_t;

  typedef logic [ROM_MAX*24-1:0] rom_image_t;

  function automatic rom_image_t default_rom();
    rom_image_t img;
    img = '0;
    img[0*24 +: 24] = {OP_ADD, 8'd100, 8'd50};
    img[1*24 +: 24] = {OP_ADD, 8'd200, 8'd100};
    img[2*24 +: 24] = {OP_SUB, 8'd10,  8'd20};
    img[3*24 +: 24] = {OP_AND, 8'hF0,  8'h3C};
    img[4*24 +: 24] = {OP_SHL, 8'h81,  8'h00};
    img[5*24 +: 24] = {OP_DEC, 8'h00,  8'h00};
    for (int i = 6; i < 16; i++) begin
      img[i*24 +: 24] = {OP_NOT, 8'h0F, 8'h00};
    end
    return img;
  endfunction

endpackage

// File: rtl/alu_cpu_core_if.sv
// rtl/alu_cpu_core_if.sv - display host bus between the ALU CPU core and its reader
//
// Purpose: bundles the host handshake and the displayed instruction fields.
// Signals:
//   next_out        host -> core  advance to next instruction (honoured in HOLD only)
//   data_out        core -> host  fields valid for readout
//   opcode          core -> host  current opcode
//   operand_A_out   core -> host  operand A (signed view)
//   operand_B_out   core -> host  operand B (signed view)
//   result_out_cpu  core -> host  ALU result, low 8 bits (signed view)
//   carry_out_cpu   core -> host  unsigned carry flag
//   borrow_out_cpu  core -> host  unsigned borrow flag
//   result_ready    core -> host  one-cycle pulse when the result updates
//   pc_out          core -> host  ROM address of the current instruction
// Modports: master = core side, slave = host side.
interface alu_cpu_core_if;
  logic              next_out;
  logic              data_out;
  logic [7:0]        opcode;
  logic signed [7:0] operand_A_out;
  logic signed [7:0] operand_B_out;
  logic signed [7:0] result_out_cpu;
  logic              carry_out_cpu;
  logic              borrow_out_cpu;
  logic              result_ready;
  logic [7:0]        pc_out;

  modport master (
    input  next_out,
    output data_out, opcode, operand_A_out, operand_B_out, result_out_cpu,
           carry_out_cpu, borrow_out_cpu, result_ready, pc_out
  );

  modport slave (
    output next_out,
    input  data_out, opcode, operand_A_out, operand_B_out, result_out_cpu,
           carry_out_cpu, borrow_out_cpu, result_ready, pc_out
  );
endinterface

// File: rtl/alu_cpu_alu.sv
// rtl/alu_cpu_alu.sv - combinational 8-bit ALU with unsigned carry/borrow flags
//
// Purpose: maps (opcode, A, B) to an 8-bit result plus carry and borrow.
// Ports:
//   opcode  in   8  operation select
//   a       in   8  operand A
//   b       in   8  operand B
//   result  out  8  low 8 bits of the result
//   carry   out  1  unsigned carry (ADD, SHL, SHR, INC, MUL)
//   borrow  out  1  unsigned borrow (SUB, DEC)
// Optional feature macro: ALU_CPU_MUL_EN enables opcode 0x08 (unsigned multiply).
// Undefined opcodes, including HALT, produce result 0 with both flags clear.
module alu_cpu_alu
  import alu_cpu_pkg::*;
(
  input  logic [7:0] opcode,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] result,
  output logic       carry,
  output logic       borrow
);

  logic [8:0] wide;

`ifdef ALU_CPU_MUL_EN
  logic [15:0] product;
  assign product = {8'h00, a} * {8'h00, b};
`else
`endif

  always_comb begin
    result = 8'h00;
    carry  = 1'b0;
    borrow = 1'b0;
    wide   = 9'h000;
    case (opcode)
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[7:0];
        carry  = wide[8];
      end
      OP_SUB: begin
        result = a - b;
        borrow = (a < b);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result = {a[6:0], 1'b0};
        carry  = a[7];
      end
      OP_SHR: begin
        result = {1'b0, a[7:1]};
        carry  = a[0];
      end
      OP_INC: begin
        wide   = {1'b0, a} + 9'd1;
        result = wide[7:0];
        carry  = wide[8];
      end
      OP_DEC: begin
        result = a - 8'd1;
        borrow = (a == 8'h00);
      end
`ifdef ALU_CPU_MUL_EN
      OP_MUL: begin
        result = product[7:0];
        carry  = |product[15:8];
      end
`else
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_cpu_core.sv
// rtl/alu_cpu_core.sv - ROM-driven ALU CPU that holds each executed instruction for a display host
//
// Purpose: steps through a fixed instruction ROM, executes each word on the ALU and
// holds opcode, operands, result, flags and PC until the host acknowledges.
// Parameters:
//   PROG_DEPTH  number of valid ROM entries (1..256); PC wraps after PROG_DEPTH-1
//   ROM_IMAGE   packed program image, word i at [i*24 +: 24]
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   synchronous active-high reset
//   bus  master side of alu_cpu_core_if (host handshake and displayed fields)
// Optional feature macro: ALU_CPU_MUL_EN (passed through to alu_cpu_alu).
module alu_cpu_core
  import alu_cpu_pkg::*;
#(
  parameter int         PROG_DEPTH = 16,
  parameter rom_image_t ROM_IMAGE  = default_rom()
) (
  input  logic           clk,
  input  logic           rst,
  alu_cpu_core_if.master bus
);

  localparam logic [7:0] PC_LAST = 8'(PROG_DEPTH - 1);

  state_t     state;
  logic [7:0] pc;
  logic [7:0] opcode_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [7:0] result_q;
  logic       carry_q;
  logic       borrow_q;
  logic       ready_q;
  logic       data_q;
  logic [7:0] pc_out_q;

  logic [12:0] rom_base;
  instr_t      word;
  logic [7:0]  alu_result;
  logic        alu_carry;
  logic        alu_borrow;

  assign rom_base = {5'd0, pc} * 13'd24;
  assign word     = ROM_IMAGE[rom_base +: 24];

  // The ALU works on the registered fields so the displayed operands and the
  // result always belong to the same instruction.
  alu_cpu_alu u_alu (
    .opcode (opcode_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result),
    .carry  (alu_carry),
    .borrow (alu_borrow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_FETCH;
      pc       <= 8'h00;
      opcode_q <= 8'h00;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      result_q <= 8'h00;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      ready_q  <= 1'b0;
      data_q   <= 1'b0;
      pc_out_q <= 8'h00;
    end else begin
      ready_q <= 1'b0;
      case (state)
        ST_FETCH: begin
          opcode_q <= word.opcode;
          a_q      <= word.a;
          b_q      <= word.b;
          pc_out_q <= pc;
          data_q   <= 1'b0;
          state    <= ST_EXEC;
        end
        ST_EXEC: begin
          // HALT decodes as an undefined opcode in the ALU, so result and
          // flags land at 0 without special handling here.
          result_q <= alu_result;
          carry_q  <= alu_carry;
          borrow_q <= alu_borrow;
          ready_q  <= 1'b1;
          if (opcode_q == OP_HALT) begin
            data_q <= 1'b0;
            state  <= ST_HALTED;
          end else begin
            data_q <= 1'b1;
            state  <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Leaving HOLD immediately means a held-high next_out advances
          // exactly once per visit.
          if (bus.next_out) begin
            pc     <= (pc == PC_LAST) ? 8'h00 : pc + 8'd1;
            data_q <= 1'b0;
            state  <= ST_FETCH;
          end
        end
        ST_HALTED: ;
        default: state <= ST_FETCH;
      endcase
    end
  end

  assign bus.data_out       = data_q;
  assign bus.opcode         = opcode_q;
  assign bus.operand_A_out  = a_q;
  assign bus.operand_B_out  = b_q;
  assign bus.result_out_cpu = result_q;
  assign bus.carry_out_cpu  = carry_q;
  assign bus.borrow_out_cpu = borrow_q;
  assign bus.result_ready   = ready_q;
  assign bus.pc_out         = pc_out_q;

endmodule

// File: tb/tb_alu_cpu_core.sv
// tb/tb_alu_cpu_core.sv - directed self-checking bench for alu_cpu_core
module tb_alu_cpu_core;
  import alu_cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  function automatic rom_image_t halt_image();
    rom_image_t img;
    img = '0;
    img[0*24 +: 24] = {8'h00, 8'd100, 8'd50};
    img[1*24 +: 24] = {8'hFF, 8'h00, 8'h00};
    return img;
  endfunction

  localparam rom_image_t HALT_IMG = halt_image();

  alu_cpu_core_if bus ();
  alu_cpu_core_if hbus ();

  alu_cpu_core #(.PROG_DEPTH(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  alu_cpu_core #(.PROG_DEPTH(16), .ROM_IMAGE(HALT_IMG)) u_halt (
    .clk (clk),
    .rst (rst),
    .bus (hbus.master)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_fields(input string tag, input logic [7:0] pc, input logic [7:0] op,
                            input logic [7:0] a, input logic [7:0] b, input logic [7:0] res,
                            input logic c, input logic bw);
    chk({tag, ".pc"},     bus.pc_out, pc);
    chk({tag, ".op"},     bus.opcode, op);
    chk({tag, ".a"},      bus.operand_A_out, a);
    chk({tag, ".b"},      bus.operand_B_out, b);
    chk({tag, ".res"},    bus.result_out_cpu, res);
    chk({tag, ".carry"},  {7'd0, bus.carry_out_cpu}, {7'd0, c});
    chk({tag, ".borrow"}, {7'd0, bus.borrow_out_cpu}, {7'd0, bw});
  endtask

  // Pulse next_out for one cycle, then wait for result_ready; checks the
  // 2-cycle latency and that the pulse lasts one cycle with data_out held.
  task automatic advance(input string tag);
    int lat;
    bus.next_out = 1'b1;
    @(negedge clk);
    bus.next_out = 1'b0;
    chk({tag, ".data_drop"}, {7'd0, bus.data_out}, 8'd0);
    lat = 0;
    while (!bus.result_ready && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 8'(lat), 8'd2);
    chk({tag, ".data_rise"}, {7'd0, bus.data_out}, 8'd1);
    @(negedge clk);
    chk({tag, ".rr_pulse"}, {7'd0, bus.result_ready}, 8'd0);
    chk({tag, ".data_hold"}, {7'd0, bus.data_out}, 8'd1);
  endtask

  logic [7:0] exp_op  [16];
  logic [7:0] exp_a   [16];
  logic [7:0] exp_b   [16];
  logic [7:0] exp_res [16];
  logic       exp_c   [16];
  logic       exp_bw  [16];

  initial begin
    int pulses;

    exp_op[0] = 8'h00; exp_a[0] = 8'd100; exp_b[0] = 8'd50;  exp_res[0] = 8'h96; exp_c[0] = 0; exp_bw[0] = 0;
    exp_op[1] = 8'h00; exp_a[1] = 8'd200; exp_b[1] = 8'd100; exp_res[1] = 8'h2C; exp_c[1] = 1; exp_bw[1] = 0;
    exp_op[2] = 8'h01; exp_a[2] = 8'd10;  exp_b[2] = 8'd20;  exp_res[2] = 8'hF6; exp_c[2] = 0; exp_bw[2] = 1;
    exp_op[3] = 8'h02; exp_a[3] = 8'hF0;  exp_b[3] = 8'h3C;  exp_res[3] = 8'h30; exp_c[3] = 0; exp_bw[3] = 0;
    exp_op[4] = 8'h06; exp_a[4] = 8'h81;  exp_b[4] = 8'h00;  exp_res[4] = 8'h02; exp_c[4] = 1; exp_bw[4] = 0;
    exp_op[5] = 8'h0A; exp_a[5] = 8'h00;  exp_b[5] = 8'h00;  exp_res[5] = 8'hFF; exp_c[5] = 0; exp_bw[5] = 1;
    for (int i = 6; i < 16; i++) begin
      exp_op[i] = 8'h05; exp_a[i] = 8'h0F; exp_b[i] = 8'h00; exp_res[i] = 8'hF0; exp_c[i] = 0; exp_bw[i] = 0;
    end

    bus.next_out  = 1'b1;   // ignored while in reset
    hbus.next_out = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_fields("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("reset.data", {7'd0, bus.data_out}, 8'd0);
    chk("reset.rr",   {7'd0, bus.result_ready}, 8'd0);

    bus.next_out = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("first.fetch_rr",   {7'd0, bus.result_ready}, 8'd0);
    chk("first.fetch_data", {7'd0, bus.data_out}, 8'd0);
    @(negedge clk);
    chk("first.rr", {7'd0, bus.result_ready}, 8'd1);
    chk_fields("pc0", 8'd0, exp_op[0], exp_a[0], exp_b[0], exp_res[0], exp_c[0], exp_bw[0]);
    chk("first.data", {7'd0, bus.data_out}, 8'd1);
    repeat (4) @(negedge clk);
    chk("hold.data", {7'd0, bus.data_out}, 8'd1);
    chk("hold.rr",   {7'd0, bus.result_ready}, 8'd0);
    chk("hold.pc",   bus.pc_out, 8'd0);

    for (int i = 1; i < 16; i++) begin
      advance($sformatf("adv%0d", i));
      chk_fields($sformatf("pc%0d", i), 8'(i), exp_op[i], exp_a[i], exp_b[i], exp_res[i], exp_c[i], exp_bw[i]);
    end

    advance("wrap");
    chk_fields("wrap", 8'd0, exp_op[0], exp_a[0], exp_b[0], exp_res[0], exp_c[0], exp_bw[0]);

    // next_out held high across several visits: one advance per HOLD visit.
    bus.next_out = 1'b1;
    pulses = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (bus.result_ready) begin
        pulses++;
        chk($sformatf("held.pc%0d", pulses), bus.pc_out, 8'(pulses));
      end
    end
    bus.next_out = 1'b0;
    chk("held.pulses", 8'(pulses), 8'd3);
    @(negedge clk);
    chk_fields("held.end", 8'd3, exp_op[3], exp_a[3], exp_b[3], exp_res[3], exp_c[3], exp_bw[3]);
    chk("held.data", {7'd0, bus.data_out}, 8'd1);

    // Reset in the middle of HOLD at pc 3.
    rst = 1'b1;
    @(negedge clk);
    chk_fields("midrst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("midrst.data", {7'd0, bus.data_out}, 8'd0);
    chk("midrst.rr",   {7'd0, bus.result_ready}, 8'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("restart.rr", {7'd0, bus.result_ready}, 8'd1);
    chk_fields("restart", 8'd0, exp_op[0], exp_a[0], exp_b[0], exp_res[0], exp_c[0], exp_bw[0]);

    // HALT at pc 1 on the second core; next_out kept high must not escape.
    chk("halt.pre_data", {7'd0, hbus.data_out}, 8'd1);
    chk("halt.pre_res",  hbus.result_out_cpu, 8'h96);
    hbus.next_out = 1'b1;
    repeat (8) @(negedge clk);
    chk("halt.data",   {7'd0, hbus.data_out}, 8'd0);
    chk("halt.rr",     {7'd0, hbus.result_ready}, 8'd0);
    chk("halt.pc",     hbus.pc_out, 8'd1);
    chk("halt.op",     hbus.opcode, 8'hFF);
    chk("halt.res",    hbus.result_out_cpu, 8'h00);
    chk("halt.carry",  {7'd0, hbus.carry_out_cpu}, 8'd0);
    chk("halt.borrow", {7'd0, hbus.borrow_out_cpu}, 8'd0);
    hbus.next_out = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
